uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     frame_err_o,
  output logic                     overrun_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [2:0]               state_o
);

  localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int TW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rxs;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      sc;
  logic [2:0]      bi;
  logic [7:0]      shreg;
  logic            push;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;
  logic            push_ok;

  assign state_o = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Held at zero while idle so the first tick lands DIV cycles after start detection.
  assign tick = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sc          <= 4'd0;
      bi          <= 3'd0;
      shreg       <= 8'h00;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            sc    <= 4'd0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sc == 4'd7) begin
              if (rxs) begin
                state <= ST_IDLE;
              end else begin
                sc    <= 4'd0;
                bi    <= 3'd0;
                state <= ST_DATA;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc    <= 4'd0;
              shreg <= {rxs, shreg[7:1]};
              bi    <= bi + 3'd1;
              if (bi == 3'd7) state <= ST_STOP;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc <= 4'd0;
              if (rxs) begin
                state <= ST_IDLE;
              end else begin
                frame_err_o <= 1'b1;
                state       <= ST_BREAK;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push = (state == ST_STOP) && tick && (sc == 4'd15) && rxs;

  // Consumer handshake: the head byte on data_o is taken on any rising edge where
  // valid_o and ready_i are both high; data_o holds the next entry one cycle later.
  assign valid_o = (count_o != '0);
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;
  assign pop     = valid_o & ready_i;
  assign push_ok = push & ((count_o < CW'(DEPTH)) | pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_o   <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= push & ~push_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 MHz / 115200 baud with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int BIT_NS = 8680;
  // rx falls on a negedge; the stop-bit push lands on the 4107th rising edge after it
  // (2 sync + 1 detect + 152 ticks of 27 cycles), i.e. 82130 ns later.
  localparam int POP_DLY = 82120;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic [3:0] count_o;
  logic [2:0] state_o;

  logic [7:0] exp_q[$];
  int checks;
  int failures;
  int fe_cnt;
  int ov_cnt;

  uart_rx_fifo #(.CLK_FREQ(50000000), .BAUD(115200), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .count_o    (count_o),
    .state_o    (state_o)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(negedge clock) begin
    if (frame_err_o) fe_cnt++;
    if (overrun_o)   ov_cnt++;
  end

  initial begin
    #2500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver and checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = stop;
    #BIT_NS;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clock);
      if (valid_o === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s observed=valid_timeout expected=valid", tag);
    end
  endtask

  task automatic drain_one(input string tag);
    bit ok;
    logic [7:0] exp;
    wait_valid(tag, 6000, ok);
    if (ok) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s observed=%0h expected=empty_queue", tag, data_o);
      end else begin
        exp = exp_q.pop_front();
        check(tag, data_o, exp);
      end
      ready_i = 1'b1;
      @(negedge clock);
      ready_i = 1'b0;
    end
  endtask

  // Directed sequence
  initial begin
    logic [7:0] b;
    bit ok;
    checks   = 0;
    failures = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
    rx       = 1'b1;
    ready_i  = 1'b0;
    reset    = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_valid", valid_o, 1'b0);
    check("rst_count", count_o, 4'd0);
    check("rst_data", data_o, 8'h00);
    check("rst_frame_err", frame_err_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_state", state_o, 3'd0);

    // Single byte
    exp_q.push_back(8'h37);
    send_byte(8'h37, 1'b1);
    wait_valid("single_valid", 100, ok);
    check("single_valid_o", valid_o, 1'b1);
    check("single_count", count_o, 4'd1);
    drain_one("single_data");
    check("single_valid_after", valid_o, 1'b0);
    check("single_count_after", count_o, 4'd0);
    check("single_no_fe", fe_cnt, 0);
    check("single_no_ov", ov_cnt, 0);

    // Glitch rejection
    @(negedge clock);
    rx = 1'b0;
    #3000;
    rx = 1'b1;
    #3000;
    check("glitch_count", count_o, 4'd0);
    check("glitch_state", state_o, 3'd0);
    check("glitch_no_fe", fe_cnt, 0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    drain_one("glitch_follow_data");

    // Framing error then break
    send_byte(8'h55, 1'b0);
    #20000;
    rx = 1'b1;
    #BIT_NS;
    check("frame_err_pulses", fe_cnt, 1);
    check("frame_err_nostore", count_o, 4'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    check("frame_follow_count", count_o, 4'd1);
    drain_one("frame_follow_data");
    check("frame_err_total", fe_cnt, 1);

    // Overrun: nine back-to-back bytes, only eight fit (write pointer wraps past 0)
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      if (i <= DEPTH) exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
    repeat (4) @(negedge clock);
    check("overrun_count", count_o, 4'd8);
    check("overrun_pulses", ov_cnt, 1);
    check("overrun_valid", valid_o, 1'b1);

    // Simultaneous push and pop on a full FIFO
    @(negedge clock);
    fork
      send_byte(8'h7E, 1'b1);
      begin
        #POP_DLY;
        check("simul_head", data_o, exp_q.pop_front());
        ready_i = 1'b1;
        #20;
        ready_i = 1'b0;
      end
    join
    exp_q.push_back(8'h7E);
    check("simul_count", count_o, 4'd8);
    check("simul_no_overrun", ov_cnt, 1);
    for (int i = 0; i < DEPTH; i++) drain_one("drain_data");
    check("drain_empty", valid_o, 1'b0);
    check("drain_queue_left", exp_q.size(), 0);

    // Reset during bit 4 of 0xFF; the remaining bits are idle-high
    @(negedge clock);
    rx = 1'b0;
    #BIT_NS;
    rx = 1'b1;
    #(4 * BIT_NS + 2000);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_count", count_o, 4'd0);
    check("midrst_data", data_o, 8'h00);
    check("midrst_state", state_o, 3'd0);
    #(5 * BIT_NS);
    check("midrst_nostore", count_o, 4'd0);
    check("midrst_no_fe", fe_cnt, 1);
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    drain_one("midrst_follow_data");
    check("final_empty", valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
